vga_sram_frame_pattern_gen: RTL

VGA_SRAM_FRAME_PATTERN_GEN -- requirements
Module: vga_sram_frame_pattern_gen

---
 rtl/vga_sram_frame_pattern_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_sram_frame_pattern_gen.sv
// Streams one frame of a test pattern into SRAM as (addr, data) beats with a valid/ready handshake.
// Pixels are visited in raster order; every coordinate and the address advance incrementally.
module vga_sram_frame_pattern_gen #(
  parameter int ADDR_BITS   = 20,
  parameter int DATA_BITS   = 16,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int COLOR_BITS  = 4,
  parameter int GRAD_SHIFT  = 5,
  parameter int CHECK_SHIFT = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [ADDR_BITS-1:0]      base_addr,
  input  logic [3*COLOR_BITS-1:0]   fill_color,
  output logic [ADDR_BITS-1:0]      addr,
  output logic [DATA_BITS-1:0]      data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int BW = (H_RES >= 8) ? H_RES / 8 : 1;
  localparam int PW = 3 * COLOR_BITS;
  localparam logic [COLOR_BITS-1:0] CMAX  = '1;
  localparam logic [COLOR_BITS-1:0] CZERO = '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q,   state_d;
  logic [ADDR_BITS-1:0]   addr_q,    addr_d;
  logic [DATA_BITS-1:0]   data_q,    data_d;
  logic                   valid_q,   valid_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic [CW-1:0]          col_q,     col_d;
  logic [RW-1:0]          row_q,     row_d;
  logic [2:0]             bar_q,     bar_d;
  logic [CW-1:0]          bar_pos_q, bar_pos_d;
  logic [1:0]             mode_q,    mode_d;
  logic [PW-1:0]          fill_q,    fill_d;

  function automatic logic [DATA_BITS-1:0] pixel(
    input logic [1:0]    m,
    input logic [PW-1:0] fill,
    input logic [CW-1:0] col,
    input logic [RW-1:0] row,
    input logic [2:0]    bar
  );
    logic [31:0]           cx, rx;
    logic [COLOR_BITS-1:0] grey;
    logic                  chk;
    logic [PW-1:0]         rgb;
    cx   = 32'(col);
    rx   = 32'(row);
    grey = COLOR_BITS'(cx >> GRAD_SHIFT);
    chk  = |(((cx >> CHECK_SHIFT) ^ (rx >> CHECK_SHIFT)) & 32'd1);
    case (m)
      2'd0:    rgb = {bar[2] ? CMAX : CZERO, bar[1] ? CMAX : CZERO, bar[0] ? CMAX : CZERO};
      2'd1:    rgb = {grey, grey, grey};
      2'd2:    rgb = {PW{chk}};
      default: rgb = fill;
    endcase
    pixel = '0;
    pixel[DATA_BITS-1 -: PW] = rgb;
  endfunction

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = done_q;
    col_d     = col_q;
    row_d     = row_q;
    bar_d     = bar_q;
    bar_pos_d = bar_pos_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    case (state_q)
      RUN: begin
        if (valid_q && ready) begin
          if (col_q == CW'(H_RES - 1) && row_q == RW'(V_RES - 1)) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_BITS'(1);
            if (col_q == CW'(H_RES - 1)) begin
              col_d     = '0;
              row_d     = row_q + RW'(1);
              bar_d     = '0;
              bar_pos_d = '0;
            end else begin
              col_d = col_q + CW'(1);
              // The last bar stops counting so it swallows any leftover columns.
              if (bar_q != 3'd7) begin
                if (bar_pos_q == CW'(BW - 1)) begin
                  bar_d     = bar_q + 3'd1;
                  bar_pos_d = '0;
                end else begin
                  bar_pos_d = bar_pos_q + CW'(1);
                end
              end
            end
            data_d = pixel(mode_q, fill_q, col_d, row_d, bar_d);
          end
        end
      end
      default: begin
        if (start) begin
          state_d   = RUN;
          mode_d    = mode;
          fill_d    = fill_color;
          addr_d    = base_addr;
          col_d     = '0;
          row_d     = '0;
          bar_d     = '0;
          bar_pos_d = '0;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          data_d    = pixel(mode, fill_color, '0, '0, '0);
        end
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      bar_q     <= '0;
      bar_pos_q <= '0;
      mode_q    <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      col_q     <= col_d;
      row_q     <= row_d;
      bar_q     <= bar_d;
      bar_pos_q <= bar_pos_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
    end
  end

  assign addr  = addr_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
